// File: rtl/gpu_mem_arbiter.sv
// gpu_mem_arbiter: round-robin Avalon-MM arbiter that merges N byte-wide masters onto one memory port.
// Ports: clock/reset (async, active-low); s_* are per-master slave slots (flat vectors, slot i at
// [i*W +: W]); m_* is the single shared master port. One read outstanding at a time; write grants
// are held for up to HOLD_LIMIT back-to-back transfers.
module gpu_mem_arbiter #(
  parameter int N_MASTERS  = 4,
  parameter int ADDR_BITS  = 32,
  parameter int DATA_BITS  = 8,
  parameter int HOLD_LIMIT = 4,
  parameter int IDX_BITS   = $clog2(N_MASTERS)
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic [N_MASTERS*ADDR_BITS-1:0] s_address,
  input  logic [N_MASTERS*DATA_BITS-1:0] s_writedata,
  input  logic [N_MASTERS-1:0]           s_write,
  input  logic [N_MASTERS-1:0]           s_read,
  output logic [N_MASTERS-1:0]           s_waitrequest,
  output logic [DATA_BITS-1:0]           s_readdata,
  output logic [N_MASTERS-1:0]           s_readdatavalid,
  output logic [ADDR_BITS-1:0]           m_address,
  output logic [DATA_BITS-1:0]           m_writedata,
  output logic                           m_write,
  output logic                           m_read,
  input  logic                           m_waitrequest,
  input  logic [DATA_BITS-1:0]           m_readdata,
  input  logic                           m_readdatavalid
);
  localparam int HB = $clog2(HOLD_LIMIT + 1);
  typedef enum logic [1:0] {IDLE, WRITE, READ_CMD, READ_WAIT} state_t;
  state_t               state_q, state_d;
  logic [IDX_BITS-1:0]  grant_q, grant_d, last_q, last_d, pick;
  logic [HB-1:0]        hold_cnt_q, hold_cnt_d;
  logic [N_MASTERS-1:0] req, sel;
  logic [ADDR_BITS-1:0] g_addr;
  logic [DATA_BITS-1:0] g_wdata;
  logic                 g_write, pick_rd, wr_done, rd_done, slot_go;
  assign req = s_read | s_write;
  // Scan priorities from furthest to nearest so the first requester after last_q wins.
  always_comb begin
    pick    = last_q;
    pick_rd = 1'b0;
    for (int k = N_MASTERS; k >= 1; k--)
      for (int j = 0; j < N_MASTERS; j++)
        if (req[j] && j == (int'(last_q) + k) % N_MASTERS) begin
          pick    = IDX_BITS'(j);
          pick_rd = s_read[j];
        end
  end
  always_comb begin
    g_addr  = '0;
    g_wdata = '0;
    g_write = 1'b0;
    sel     = '0;
    for (int j = 0; j < N_MASTERS; j++)
      if (grant_q == IDX_BITS'(j)) begin
        g_addr  = s_address[j*ADDR_BITS +: ADDR_BITS];
        g_wdata = s_writedata[j*DATA_BITS +: DATA_BITS];
        g_write = s_write[j];
        sel[j]  = 1'b1;
      end
  end
  assign wr_done = state_q == WRITE && g_write && !m_waitrequest;
  // A zero-latency memory returns data in the accept cycle; that counts as read completion.
  assign rd_done = m_readdatavalid && (state_q == READ_WAIT || (state_q == READ_CMD && !m_waitrequest));
  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    last_d     = last_q;
    hold_cnt_d = hold_cnt_q;
    case (state_q)
      IDLE:
        if (|req) begin
          grant_d    = pick;
          last_d     = pick;
          hold_cnt_d = '0;
          state_d    = pick_rd ? READ_CMD : WRITE;
        end
      WRITE:
        if (!g_write) state_d = IDLE;
        else if (wr_done) begin
          hold_cnt_d = hold_cnt_q + 1'b1;
          state_d    = int'(hold_cnt_q) + 1 < HOLD_LIMIT ? WRITE : IDLE;
        end
      READ_CMD:
        if (!m_waitrequest) state_d = m_readdatavalid ? IDLE : READ_WAIT;
      default:
        if (m_readdatavalid) state_d = IDLE;
    endcase
  end
  assign m_write         = state_q == WRITE && g_write;
  assign m_read          = state_q == READ_CMD;
  assign m_address       = state_q == WRITE || state_q == READ_CMD ? g_addr : '0;
  assign m_writedata     = state_q == WRITE ? g_wdata : '0;
  // Stale read data outside a read (e.g. after reset) never reaches rd_done, so it is dropped.
  assign slot_go         = state_q == WRITE ? !m_waitrequest : rd_done;
  assign s_waitrequest   = slot_go ? ~sel : '1;
  assign s_readdatavalid = rd_done ? sel : '0;
  assign s_readdata      = m_readdata;
  always_ff @(posedge clock or negedge reset)
    if (!reset) begin
      state_q    <= IDLE;
      grant_q    <= '0;
      last_q     <= IDX_BITS'(N_MASTERS - 1);
      hold_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      last_q     <= last_d;
      hold_cnt_q <= hold_cnt_d;
    end
endmodule
